// File: rtl/io_ctrl.sv
// CPU-facing I/O controller: RAM/IO address decode, UART TX FIFO, RX byte read,
// free-running cycle counter with byte-wise snapshot reads, and a sticky stop flag.
module io_ctrl #(
   parameter int TX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [16:0] ram_a,
   output logic [7:0]  ram_din,
   output logic        ram_we,
   input  logic [7:0]  ram_dout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_finish
);

   localparam int             AW         = $clog2(TX_DEPTH);
   localparam logic [AW:0]    DEPTH_CNT  = (AW+1)'(TX_DEPTH);
   localparam logic [AW:0]    FULL_LEVEL = (AW+1)'(TX_DEPTH - FULL_MARGIN);

   typedef enum logic [2:0] {
      SRC_RAM,
      SRC_RX,
      SRC_ZERO,
      SRC_CLK0,
      SRC_CLK1,
      SRC_CLK2,
      SRC_CLK3
   } src_e;

   src_e            r_src;
   src_e            w_src_nxt;
   logic [31:0]     r_cnt;
   logic [31:0]     r_snap;
   logic [7:0]      r_rx;
   logic            r_finish;
   logic            r_full;
   logic [7:0]      r_mem [TX_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [AW:0]     w_count_nxt;

   logic            w_is_io;
   logic            w_io_rd;
   logic            w_io_wr;
   logic [2:0]      w_sel;
   logic            w_rd_data;
   logic            w_rd_clk0;
   logic            w_push_req;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_fin;
   logic [7:0]      w_push_data;
   logic            w_unused_addr;

   // Only bits 17:0 of the CPU address take part in decoding.
   assign w_unused_addr = ^mem_a[31:18];

   assign w_is_io   = (mem_a[17:16] == 2'b11);
   assign w_io_rd   = rdy_in & w_is_io & ~mem_wr;
   assign w_io_wr   = rdy_in & w_is_io & mem_wr;
   assign w_sel     = mem_a[2:0];
   assign w_rd_data = w_io_rd & (w_sel == 3'd0);
   assign w_rd_clk0 = w_io_rd & (w_sel == 3'd4);
   assign w_fin     = w_io_wr & (w_sel == 3'd4);

   assign w_push_req  = w_io_wr & (((w_sel == 3'd0) & (mem_dout != 8'h00)) | (w_sel == 3'd4));
   assign w_push_data = (w_sel == 3'd4) ? 8'h00 : mem_dout;
   assign w_full      = (r_count == DEPTH_CNT);
   assign w_pop       = (r_count != '0) & tx_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push      = w_push_req & (~w_full | w_pop);

   assign ram_a          = mem_a[16:0];
   assign ram_din        = mem_dout;
   assign ram_we         = mem_wr & rdy_in & ~w_is_io;
   assign rx_pop         = rst_in & w_rd_data & rx_valid;
   assign tx_valid       = (r_count != '0);
   assign tx_data        = r_mem[r_rd_ptr];
   assign io_buffer_full = r_full;
   assign program_finish = r_finish;

   // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it holding a value (which would infer a latch).
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_src_nxt = SRC_RAM;
      if (w_is_io) begin
         if (mem_wr) begin
            w_src_nxt = SRC_ZERO;
         end else begin
            case (w_sel)
               3'd0:    w_src_nxt = SRC_RX;
               3'd4:    w_src_nxt = SRC_CLK0;
               3'd5:    w_src_nxt = SRC_CLK1;
               3'd6:    w_src_nxt = SRC_CLK2;
               3'd7:    w_src_nxt = SRC_CLK3;
               default: w_src_nxt = SRC_ZERO;
            endcase
         end
      end
   end

   always_comb begin
      mem_din = 8'h00;
      case (r_src)
         SRC_RAM:  mem_din = ram_dout;
         SRC_RX:   mem_din = r_rx;
         SRC_CLK0: mem_din = r_snap[7:0];
         SRC_CLK1: mem_din = r_snap[15:8];
         SRC_CLK2: mem_din = r_snap[23:16];
         SRC_CLK3: mem_din = r_snap[31:24];
         default:  mem_din = 8'h00;
      endcase
   end

   // NOTE: the FIFO storage has no reset; the cleared pointers and count already make old contents unreachable.
   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_cnt    <= '0;
         r_snap   <= '0;
         r_rx     <= '0;
         r_finish <= 1'b0;
         r_full   <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_src    <= SRC_RAM;
      end else begin
         r_cnt   <= r_cnt + 32'd1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt >= FULL_LEVEL);
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_fin) begin
            r_finish <= 1'b1;
         end
         if (w_rd_clk0) begin
            r_snap <= r_cnt;
         end
         if (w_rd_data) begin
            r_rx <= rx_valid ? rx_data : 8'h00;
         end
         if (rdy_in) begin
            r_src <= w_src_nxt;
         end
      end
   end

endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 Parameter TX_DEPTH, default 8, TX FIFO entries (power of two, >=4).
REQ-002 Parameter FULL_MARGIN, default 2, free entries left when io_buffer_full asserts.
REQ-003 clk_in  input  1  system clock; all state on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  CPU ready; low = CPU accesses ignored.
REQ-006 mem_a  input  32  CPU address bus; bits 17:0 decoded.
REQ-007 mem_dout  input  8  CPU write data.
REQ-008 mem_wr  input  1  CPU write strobe, 1 = write.
REQ-009 mem_din  output  8  read data to CPU, valid the cycle after the request.
REQ-010 io_buffer_full  output  1  TX FIFO almost-full flag to CPU.
REQ-011 ram_a  output  17  RAM address, equals mem_a[16:0].
REQ-012 ram_din  output  8  RAM write data, equals mem_dout.
REQ-013 ram_we  output  1  RAM write enable.
REQ-014 ram_dout  input  8  RAM read data, 1-cycle latency.
REQ-015 tx_data  output  8  FIFO head byte to UART transmitter.
REQ-016 tx_valid  output  1  FIFO non-empty.
REQ-017 tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-018 rx_data  input  8  received byte from UART receiver.
REQ-019 rx_valid  input  1  rx_data holds an unread byte.
REQ-020 rx_pop  output  1  one-cycle consume pulse to receiver.
REQ-021 program_finish  output  1  sticky; set by stop write.

Function
REQ-022 Decode: IO when mem_a[17:16]==2'b11, else RAM; only mem_a[2:0] distinguish IO registers (0x30000 data, 0x30004-0x30007 clock).
REQ-023 ram_we SHALL equal mem_wr & rdy_in & RAM-decode, combinationally; IO accesses never assert ram_we.
REQ-024 A registered source select (RAM / RX byte / clock byte 0-3) captured each rdy_in-high cycle SHALL steer mem_din the next cycle; RAM source passes ram_dout combinationally.
REQ-025 Read 0x30000 with rx_valid=1: rx_pop pulses that cycle, rx_data registered, returned next cycle; with rx_valid=0: returns 0x00, no pop.
REQ-026 32-bit cycle counter increments every cycle after reset regardless of rdy_in, wraps 0xFFFFFFFF->0.
REQ-027 Read 0x30004 SHALL snapshot the counter and return snapshot byte 0 next cycle; reads 0x30005-0x30007 return snapshot bytes 1-3 (little-endian) without re-snapshot.
REQ-028 Write 0x30000 with nonzero data pushes mem_dout into TX FIFO; data 0x00 is ignored.
REQ-029 Write 0x30004 pushes 0x00 into TX FIFO and sets program_finish; later writes keep it set.
REQ-030 Pop when tx_valid & tx_ready; tx_data = head entry, combinational from FIFO storage.
REQ-031 Push when full is dropped unless a pop occurs the same cycle, in which case both complete and count is unchanged.
REQ-032 Simultaneous push and pop at non-full: count unchanged, pointers both advance, wrap modulo TX_DEPTH.
REQ-033 io_buffer_full = (count >= TX_DEPTH - FULL_MARGIN), registered from next-state count.
REQ-034 rdy_in low: no push, no rx_pop, no snapshot, no source-select update, ram_we=0; FIFO drain and counter continue.
REQ-035 IO reads of 0x30001-0x30003 return 0x00; IO writes other than 0x30000/0x30004 are ignored.

Reset
REQ-036 rst_in low asynchronously clears: counter, snapshot, FIFO pointers and count, program_finish, source select (RAM), rx register; outputs io_buffer_full=0, tx_valid=0, rx_pop=0, mem_din follows ram_dout.
REQ-037 Reset asserted mid-transfer discards FIFO contents; no tx_valid until the next push after release.

Verification
REQ-038 Write 0x41,0x00,0x42 to 0x30000, tx_ready=1 -> tx_data 0x41 then 0x42, exactly two pops.
REQ-039 10 pushes, tx_ready=0 -> io_buffer_full=1 after 6th push, 9th/10th dropped, drain yields first 8 bytes in order.
REQ-040 Run 100 cycles after reset, read 0x30004..0x30007 -> bytes form snapshot 0x00000064 +/- capture cycle exactly, bytes consistent.
REQ-041 rx_valid=1 rx_data=0x5A, read 0x30000 -> rx_pop one cycle, mem_din=0x5A next cycle; rx_valid=0 -> mem_din=0x00.
REQ-042 rdy_in=0 with write 0x30000 data 0x33 and RAM write -> no push, ram_we=0; write 0x30004 -> program_finish=1, 0x00 transmitted.
REQ-043 Assert rst_in low with 3 bytes queued -> tx_valid, io_buffer_full, program_finish 0 immediately, without clock edge.
